// File: rtl/adc_cap_pkg.sv
// adc_cap_pkg: shared types and constants for the ADC capture engine.
//   state_t   : capture FSM states (IDLE / CAPTURE / DRAIN)
//   DEF_*     : default parameter values
//   frame_w() : width of one captured frame (all channels side by side)
package adc_cap_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  localparam int DEF_CH_NUM = 2;
  localparam int DEF_DATA_W = 18;
  localparam int DEF_DEPTH  = 64;
  localparam int DEF_CNT_W  = 16;
  localparam int DEF_DIV_W  = 8;

  function automatic int frame_w(input int ch_num, input int data_w);
    return ch_num * data_w;
  endfunction

endpackage

// File: rtl/adc_cap_engine_if.sv
// adc_cap_engine_if: serialised sample stream toward the packet controller.
//   out_data  : sample value
//   out_ch    : channel index of out_data
//   out_valid : stream valid (driven by master)
//   out_ready : stream ready (driven by slave)
// Modports: master (capture engine side), slave (consumer side).
interface adc_cap_engine_if
  import adc_cap_pkg::*;
#(
  parameter int CH_NUM = DEF_CH_NUM,
  parameter int DATA_W = DEF_DATA_W
);
  localparam int CH_W = $clog2(CH_NUM);

  logic [DATA_W-1:0] out_data;
  logic [CH_W-1:0]   out_ch;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, output out_ch, output out_valid, input out_ready);
  modport slave  (input out_data, input out_ch, input out_valid, output out_ready);
endinterface

// File: rtl/adc_cap_fifo.sv
// adc_cap_fifo: synchronous show-ahead FIFO of whole capture frames.
//   clk, rst : clock, asynchronous active-high reset (flushes pointers)
//   push/din : write request and frame; ignored when full unless popping
//   pop/dout : read request; dout always presents the head frame
//   full, empty, count : occupancy status
module adc_cap_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 36
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty.
  assign count = wr_ptr_reg - rd_ptr_reg;
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (count == (AW+1)'(DEPTH));

  assign do_pop  = pop && !empty;
  // A push into a full FIFO succeeds when the head is popped in the same cycle;
  // the write slot equals the slot being vacated, and the read is combinational.
  assign do_push = push && (!full || do_pop);

  assign dout = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end
endmodule

// File: rtl/adc_cap_engine.sv
// adc_cap_engine: multi-channel ADC capture engine.
// Samples CH_NUM channels every max(cfg_clk_div,1) cycles, buffers frames in
// adc_cap_fifo and serialises the enabled channels onto the strm interface.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   cfg_start/abort   : one-cycle control pulses
//   cfg_len           : frames to capture (0 = until abort)
//   cfg_clk_div       : sample period in cycles (0 treated as 1)
//   cfg_ch_mask       : enabled channels
//   cfg_self_test     : ramp pattern instead of ADC data
//   adc_data/valid    : ADC input, channel c at [c*DATA_W +: DATA_W]
//   strm (master)     : out_data / out_ch / out_valid / out_ready stream
//   busy, done        : FSM not idle / end-of-capture pulse
//   overflow          : sticky dropped-frame flag
//   frame_cnt         : frames pushed since last start
// Optional feature macro: ADC_CAP_SELF_TEST_EN builds the ramp generator.
module adc_cap_engine
  import adc_cap_pkg::*;
#(
  parameter int CH_NUM = DEF_CH_NUM,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int DIV_W  = DEF_DIV_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_start,
  input  logic                     cfg_abort,
  input  logic [CNT_W-1:0]         cfg_len,
  input  logic [DIV_W-1:0]         cfg_clk_div,
  input  logic [CH_NUM-1:0]        cfg_ch_mask,
  input  logic                     cfg_self_test,
  input  logic [CH_NUM*DATA_W-1:0] adc_data,
  input  logic                     adc_valid,
  adc_cap_engine_if.master         strm,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow,
  output logic [CNT_W-1:0]         frame_cnt
);
  localparam int FW   = frame_w(CH_NUM, DATA_W);
  localparam int CH_W = $clog2(CH_NUM);
  localparam int QW   = $clog2(DEPTH) + 1;

  state_t            state_reg;
  logic [CNT_W-1:0]  len_reg;
  logic [DIV_W-1:0]  div_reg;
  logic [DIV_W-1:0]  div_cnt_reg;
  logic [CH_NUM-1:0] mask_reg;
  logic [CNT_W-1:0]  frame_cnt_reg;
  logic              overflow_reg;
  logic              done_reg;
  logic              out_valid_reg;
  logic [CH_W-1:0]   ch_reg;

  logic              strobe;
  logic              frame_ok;
  logic [FW-1:0]     frame_data;
  logic              want_push;
  logic              fifo_push;
  logic              fifo_pop;
  logic              drop;
  logic              accept;
  logic [CNT_W-1:0]  cnt_next;
  logic [FW-1:0]     fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [QW-1:0]     fifo_count;
  logic [CH_W-1:0]   first_ch;
  logic [CH_W-1:0]   next_ch;
  logic              has_next;
  logic [DATA_W-1:0] head_ch [CH_NUM];

`ifdef ADC_CAP_SELF_TEST_EN
  logic              st_reg;
  logic [DATA_W-1:0] ramp_reg;
  logic [FW-1:0]     ramp_frame;

  for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ramp
    assign ramp_frame[gi*DATA_W +: DATA_W] = ramp_reg + DATA_W'(gi);
  end

  // Self-test frames are always considered valid.
  assign frame_ok   = st_reg | adc_valid;
  assign frame_data = st_reg ? ramp_frame : adc_data;
`else
  logic unused_self_test;
  assign unused_self_test = cfg_self_test;
  assign frame_ok   = adc_valid;
  assign frame_data = adc_data;
`endif

  assign strobe    = (state_reg == CAPTURE) && (div_cnt_reg == '0);
  assign want_push = strobe && frame_ok && (|mask_reg);
  assign accept    = out_valid_reg && strm.out_ready;
  assign fifo_pop  = accept && !has_next;
  assign fifo_push = want_push && (!fifo_full || fifo_pop);
  assign drop      = want_push && fifo_full && !fifo_pop;
  assign cnt_next  = frame_cnt_reg + CNT_W'(fifo_push);

  // Lowest enabled channel, and the next enabled channel above ch_reg.
  always_comb begin
    first_ch = '0;
    next_ch  = '0;
    has_next = 1'b0;
    for (int c = CH_NUM - 1; c >= 0; c--) begin
      if (mask_reg[c]) first_ch = CH_W'(c);
      if (mask_reg[c] && (CH_W'(c) > ch_reg)) begin
        next_ch  = CH_W'(c);
        has_next = 1'b1;
      end
    end
  end

  adc_cap_fifo #(.DEPTH(DEPTH), .WIDTH(FW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (frame_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_head
    assign head_ch[gi] = fifo_dout[gi*DATA_W +: DATA_W];
  end

  // Data follows the held FIFO head, so it is stable while stalled.
  assign strm.out_valid = out_valid_reg;
  assign strm.out_data  = out_valid_reg ? head_ch[ch_reg] : '0;
  assign strm.out_ch    = out_valid_reg ? ch_reg : '0;

  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign overflow  = overflow_reg;
  assign frame_cnt = frame_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      len_reg       <= '0;
      div_reg       <= '0;
      div_cnt_reg   <= '0;
      mask_reg      <= '0;
      frame_cnt_reg <= '0;
      overflow_reg  <= 1'b0;
      done_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      ch_reg        <= '0;
`ifdef ADC_CAP_SELF_TEST_EN
      st_reg        <= 1'b0;
      ramp_reg      <= '0;
`endif
    end else begin
      done_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (cfg_start) begin
            len_reg       <= cfg_len;
            div_reg       <= (cfg_clk_div == '0) ? DIV_W'(1) : cfg_clk_div;
            mask_reg      <= cfg_ch_mask;
            frame_cnt_reg <= '0;
            overflow_reg  <= 1'b0;
            div_cnt_reg   <= '0;
`ifdef ADC_CAP_SELF_TEST_EN
            st_reg        <= cfg_self_test;
            ramp_reg      <= '0;
`endif
            state_reg     <= (|cfg_ch_mask) ? CAPTURE : DRAIN;
          end
        end
        CAPTURE: begin
          div_cnt_reg <= (div_cnt_reg == div_reg - 1'b1) ? '0 : div_cnt_reg + 1'b1;
          if (fifo_push) begin
            frame_cnt_reg <= cnt_next;
`ifdef ADC_CAP_SELF_TEST_EN
            ramp_reg      <= ramp_reg + 1'b1;
`endif
          end
          if (drop) overflow_reg <= 1'b1;
          // A push landing together with abort still completes above.
          if (cfg_abort || ((len_reg != '0) && (cnt_next == len_reg)))
            state_reg <= DRAIN;
        end
        DRAIN: begin
          if (fifo_empty && !out_valid_reg) begin
            state_reg <= IDLE;
            done_reg  <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase

      // Serialiser: load the head frame, step through enabled channels,
      // pop after the last one and continue straight into the next frame.
      if (!out_valid_reg) begin
        if (!fifo_empty) begin
          out_valid_reg <= 1'b1;
          ch_reg        <= first_ch;
        end
      end else if (accept) begin
        if (has_next) begin
          ch_reg <= next_ch;
        end else begin
          ch_reg        <= first_ch;
          out_valid_reg <= (fifo_count > QW'(1)) || fifo_push;
        end
      end
    end
  end
endmodule

// File: tb/tb_adc_cap_engine.sv
module tb_adc_cap_engine;
  localparam int DW = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_start, cfg_abort, cfg_self_test, adc_valid;
  logic [15:0]   cfg_len;
  logic [7:0]    cfg_clk_div;
  logic [1:0]    cfg_ch_mask;
  logic [2*DW-1:0] adc_data;
  logic          busy, done, overflow;
  logic [15:0]   frame_cnt;

  int n_cmp = 0;
  int n_fail = 0;

  adc_cap_engine_if #(.CH_NUM(2), .DATA_W(DW)) strm ();

  adc_cap_engine dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_start     (cfg_start),
    .cfg_abort     (cfg_abort),
    .cfg_len       (cfg_len),
    .cfg_clk_div   (cfg_clk_div),
    .cfg_ch_mask   (cfg_ch_mask),
    .cfg_self_test (cfg_self_test),
    .adc_data      (adc_data),
    .adc_valid     (adc_valid),
    .strm          (strm),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow),
    .frame_cnt     (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cap(input logic [15:0] len, input logic [7:0] div,
                           input logic [1:0] mask, input logic st);
    cfg_len = len; cfg_clk_div = div; cfg_ch_mask = mask; cfg_self_test = st;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    n_cmp++; if ({busy, done, overflow, strm.out_valid} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {busy, done, overflow, strm.out_valid}); end
    n_cmp++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
    n_cmp++; if ({strm.out_data, strm.out_ch} !== 19'd0) begin n_fail++; $display("FAIL reset_out: got %0h want 0", {strm.out_data, strm.out_ch}); end
    rst = 1'b0;
    tick();
    $display("reset: done");
  endtask

  task automatic test_basic();
    int nb, first_v, fc;
    bit got_done, bz;
    logic [0:0]    bch [16];
    logic [DW-1:0] bdat [16];
    nb = 0; first_v = -1; got_done = 0; fc = 0; bz = 1;
    strm.out_ready = 1'b1; adc_valid = 1'b1;
    adc_data = {18'd1, 18'd0};
    start_cap(16'd4, 8'd1, 2'b11, 1'b1);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy); end
    for (int cyc = 0; cyc < 60; cyc++) begin
      // Matches the ramp so the result is the same with or without self-test.
      adc_data = {18'(cyc + 1), 18'(cyc)};
      if (strm.out_valid && first_v < 0) first_v = cyc;
      if (strm.out_valid && strm.out_ready && nb < 16) begin
        bch[nb] = strm.out_ch; bdat[nb] = strm.out_data; nb++;
      end
      if (done) begin got_done = 1; fc = frame_cnt; bz = busy; break; end
      tick();
    end
    n_cmp++; if (!got_done) begin n_fail++; $display("FAIL basic_done: got 0 want 1"); end
    n_cmp++; if (first_v !== 2) begin n_fail++; $display("FAIL basic_latency: got %0d want 2", first_v); end
    n_cmp++; if (nb !== 8) begin n_fail++; $display("FAIL basic_beats: got %0d want 8", nb); end
    for (int j = 0; j < 8 && j < nb; j++) begin
      n_cmp++;
      if (bch[j] !== 1'(j % 2) || bdat[j] !== 18'(j / 2 + j % 2)) begin
        n_fail++; $display("FAIL basic_beat%0d: got (%0d,%0h) want (%0d,%0h)", j, bch[j], bdat[j], j % 2, j / 2 + j % 2);
      end
    end
    n_cmp++; if (fc !== 4) begin n_fail++; $display("FAIL basic_frame_cnt: got %0d want 4", fc); end
    n_cmp++; if (bz !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done: got %b want 0", bz); end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_width: got %b want 0", done); end
    $display("basic: %0d beats, done=%0d", nb, got_done);
  endtask

  task automatic test_mask_div();
    int nb;
    int bcyc [8];
    bit got_done, bad;
    nb = 0; got_done = 0; bad = 0;
    strm.out_ready = 1'b1; adc_valid = 1'b1;
    adc_data = {18'h155, 18'h2AA};
    start_cap(16'd3, 8'd3, 2'b10, 1'b0);
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (strm.out_valid && strm.out_ready) begin
        if (strm.out_ch !== 1'b1 || strm.out_data !== 18'h155) bad = 1;
        if (nb < 8) bcyc[nb] = cyc;
        nb++;
      end
      if (done) begin got_done = 1; break; end
      tick();
    end
    n_cmp++; if (nb !== 3) begin n_fail++; $display("FAIL maskdiv_beats: got %0d want 3", nb); end
    n_cmp++; if (bad) begin n_fail++; $display("FAIL maskdiv_data: got wrong ch/data want (1,155)"); end
    n_cmp++; if (nb >= 3 && (bcyc[1] - bcyc[0] !== 3 || bcyc[2] - bcyc[1] !== 3)) begin
      n_fail++; $display("FAIL maskdiv_spacing: got %0d,%0d want 3,3", bcyc[1] - bcyc[0], bcyc[2] - bcyc[1]);
    end
    n_cmp++; if (!got_done || frame_cnt !== 16'd3) begin n_fail++; $display("FAIL maskdiv_done: got done=%0d cnt=%0d want 1,3", got_done, frame_cnt); end
    tick();
    $display("mask_div: %0d beats", nb);
  endtask

  task automatic test_overflow();
    int nb, nfr;
    bit got_done, bad;
    nb = 0; nfr = 0; got_done = 0; bad = 0;
    strm.out_ready = 1'b0; adc_valid = 1'b1;
    adc_data = {18'h22, 18'h11};
    start_cap(16'd0, 8'd1, 2'b11, 1'b0);
    repeat (64) tick();
    n_cmp++; if (frame_cnt !== 16'd64 || overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_fill: got cnt=%0d ovf=%b want 64,0", frame_cnt, overflow); end
    repeat (6) tick();
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    n_cmp++; if (frame_cnt !== 16'd64) begin n_fail++; $display("FAIL ovf_cnt: got %0d want 64", frame_cnt); end
    n_cmp++; if (strm.out_valid !== 1'b1 || strm.out_data !== 18'h11 || strm.out_ch !== 1'b0) begin
      n_fail++; $display("FAIL ovf_head: got v=%b (%0d,%0h) want 1 (0,11)", strm.out_valid, strm.out_ch, strm.out_data);
    end
    cfg_abort = 1'b1; strm.out_ready = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (strm.out_valid && strm.out_ready) begin
        nb++;
        if (strm.out_data !== (strm.out_ch ? 18'h22 : 18'h11)) bad = 1;
        if (strm.out_ch == 1'b1) nfr++;
      end
      if (done) begin got_done = 1; break; end
      tick();
      cfg_abort = 1'b0;
    end
    cfg_abort = 1'b0;
    n_cmp++; if (nb !== 128 || nfr !== 64) begin n_fail++; $display("FAIL ovf_drain: got %0d beats %0d frames want 128,64", nb, nfr); end
    n_cmp++; if (bad) begin n_fail++; $display("FAIL ovf_data: got wrong data want 11/22"); end
    n_cmp++; if (!got_done || frame_cnt !== 16'd64 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_end: got done=%0d cnt=%0d ovf=%b want 1,64,1", got_done, frame_cnt, overflow);
    end
    tick();
    $display("overflow: drained %0d beats", nb);
  endtask

  task automatic test_back_to_back();
    int nb;
    bit got_done, prev_stall;
    logic [DW-1:0] prev_d;
    logic [0:0]    prev_c;
    logic [DW-1:0] exp_d;
    nb = 0; got_done = 0; prev_stall = 0; prev_d = '0; prev_c = '0;
    strm.out_ready = 1'b0; adc_valid = 1'b1;
    adc_data = {18'd100, 18'd0};
    start_cap(16'd6, 8'd2, 2'b11, 1'b0);
    for (int cyc = 0; cyc < 300; cyc++) begin
      // Strobes fall on even cycles: frame k = {2k+100, 2k}.
      adc_data = {18'(cyc + 100), 18'(cyc)};
      strm.out_ready = 1'($urandom_range(0, 1));
      if (prev_stall) begin
        n_cmp++;
        if (strm.out_data !== prev_d || strm.out_ch !== prev_c) begin
          n_fail++; $display("FAIL bp_stable: got (%0d,%0h) want (%0d,%0h)", strm.out_ch, strm.out_data, prev_c, prev_d);
        end
      end
      if (strm.out_valid && strm.out_ready) begin
        exp_d = 18'((nb / 2) * 2 + (nb % 2) * 100);
        n_cmp++;
        if (strm.out_ch !== 1'(nb % 2) || strm.out_data !== exp_d) begin
          n_fail++; $display("FAIL bp_beat%0d: got (%0d,%0h) want (%0d,%0h)", nb, strm.out_ch, strm.out_data, nb % 2, exp_d);
        end
        nb++;
      end
      prev_stall = strm.out_valid && !strm.out_ready;
      prev_d = strm.out_data; prev_c = strm.out_ch;
      if (done) begin got_done = 1; break; end
      tick();
    end
    n_cmp++; if (nb !== 12 || !got_done) begin n_fail++; $display("FAIL bp_count: got %0d beats done=%0d want 12,1", nb, got_done); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL bp_overflow: got %b want 0", overflow); end
    strm.out_ready = 1'b1;
    tick();
    $display("back_to_back: %0d beats", nb);
  endtask

  task automatic test_edge_cases();
    int nb;
    bit got_done, bad;
    // Empty mask: straight to DRAIN, done one cycle later, no beats.
    strm.out_ready = 1'b1;
    start_cap(16'd2, 8'd1, 2'b00, 1'b0);
    n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL mask0_drain: got busy=%b done=%b want 1,0", busy, done); end
    tick();
    n_cmp++; if (done !== 1'b1 || busy !== 1'b0 || frame_cnt !== 16'd0 || strm.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL mask0_done: got done=%b busy=%b cnt=%0d v=%b want 1,0,0,0", done, busy, frame_cnt, strm.out_valid);
    end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL mask0_pulse: got %b want 0", done); end

    // Start while busy must not relatch configuration.
    nb = 0; got_done = 0; bad = 0;
    adc_valid = 1'b1; adc_data = {18'h3, 18'h5};
    start_cap(16'd3, 8'd1, 2'b01, 1'b0);
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (cyc == 1) begin cfg_len = 16'd10; cfg_ch_mask = 2'b11; cfg_start = 1'b1; end
      else cfg_start = 1'b0;
      if (strm.out_valid && strm.out_ready) begin
        nb++;
        if (strm.out_ch !== 1'b0 || strm.out_data !== 18'h5) bad = 1;
      end
      if (done) begin got_done = 1; break; end
      tick();
    end
    cfg_start = 1'b0;
    n_cmp++; if (nb !== 3 || bad || !got_done || frame_cnt !== 16'd3) begin
      n_fail++; $display("FAIL start_busy: got beats=%0d bad=%0d done=%0d cnt=%0d want 3,0,1,3", nb, bad, got_done, frame_cnt);
    end
    tick();

    // Reset mid-capture.
    strm.out_ready = 1'b0;
    start_cap(16'd0, 8'd1, 2'b11, 1'b0);
    repeat (10) tick();
    rst = 1'b1;
    #1;
    n_cmp++; if ({busy, done, overflow, strm.out_valid} !== 4'b0 || frame_cnt !== 16'd0 || {strm.out_data, strm.out_ch} !== 19'd0) begin
      n_fail++; $display("FAIL rst_mid: got busy=%b done=%b ovf=%b v=%b cnt=%0d want all 0", busy, done, overflow, strm.out_valid, frame_cnt);
    end
    tick();
    rst = 1'b0;
    strm.out_ready = 1'b1;
    bad = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (strm.out_valid || done || busy) bad = 1;
      tick();
    end
    n_cmp++; if (bad) begin n_fail++; $display("FAIL rst_after: got activity after reset want none"); end
    $display("edge_cases: done");
  endtask

  initial begin
    rst = 1'b1; cfg_start = 1'b0; cfg_abort = 1'b0; cfg_self_test = 1'b0;
    cfg_len = '0; cfg_clk_div = '0; cfg_ch_mask = '0; adc_data = '0; adc_valid = 1'b0;
    strm.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_mask_div();
    test_overflow();
    test_back_to_back();
    test_edge_cases();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/adc_cap_engine.md
# adc_cap_engine

Parametrised multi-channel ADC capture engine. It samples CH_NUM parallel ADC channels at a programmable decimated rate, buffers whole frames in an internal FIFO, and serialises the enabled channels onto a valid/ready stream toward the packet controller. It sits between the ADC input pads and the packet controller in digital_top, and is driven by regfile fields: start, abort, length, divider, channel mask and self-test.

## Interface
- CH_NUM, 2: channel count, minimum 2.
- DATA_W, 18: sample width.
- DEPTH, 64: FIFO depth in frames, power of 2.
- CNT_W, 16: frame-length and frame-counter width.
- DIV_W, 8: divider width.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- cfg_start  in  1  one-cycle capture start pulse.
- cfg_abort  in  1  one-cycle pulse; stops capture and drains the FIFO.
- cfg_len  in  CNT_W  frames to capture; 0 means continuous until abort.
- cfg_clk_div  in  DIV_W  sample period in clk cycles; 0 is treated as 1.
- cfg_ch_mask  in  CH_NUM  enabled channels.
- cfg_self_test  in  1  select the ramp pattern instead of ADC data.
- adc_data  in  CH_NUM*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W].
- adc_valid  in  1  ADC data qualifier.
- out_data  out  DATA_W  serialised sample.
- out_ch  out  $clog2(CH_NUM)  channel index of out_data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse at the end of a capture.
- overflow  out  1  sticky dropped-frame flag.
- frame_cnt  out  CNT_W  frames pushed since the last start.

## Operation
- FSM states are IDLE, CAPTURE and DRAIN. All outputs reset to 0, and the FSM resets to IDLE.
- **IDLE, on cfg_start:**
  - Latch len, div, mask and self_test.
  - Clear frame_cnt, overflow, the ramp and the divider counter.
  - Go to CAPTURE. If the latched mask is 0, go directly to DRAIN instead.
- cfg_start while busy is ignored.
- **Sample strobe:** the divider counter runs 0..D-1, where D = max(div,1). The strobe fires when the counter is 0.
- **Frame capture, on a strobe in CAPTURE:**
  - The frame is adc_data, or the ramp in self-test.
  - Self-test channel c = ramp + c, mod 2^DATA_W.
  - Push when adc_valid (always in self-test), the FIFO is not full, and the mask is non-zero.
  - On a push: frame_cnt += 1, and ramp += 1 with wrap.
  - If the FIFO is full: drop the frame, set overflow, and leave frame_cnt and the ramp unchanged.
  - adc_valid low: no push, no count.
- **Capture end:** CAPTURE goes to DRAIN when frame_cnt reaches len (len ≠ 0) or on cfg_abort. Abort and the final push in the same cycle means the push completes.
- **Serialiser:**
  - Takes the FIFO head frame.
  - Emits enabled channels in ascending index order, one per out_valid && out_ready.
  - Pops the frame after the last enabled channel is accepted.
- **DRAIN to IDLE:** happens when the FIFO is empty and the serialiser is idle. done pulses on that transition.
- cfg_abort in IDLE or DRAIN is ignored.
- **rst mid-operation:** the FIFO is flushed, all state is cleared, and no done pulse is produced.

## Timing
- cfg_start is sampled at edge E0. busy is high after E0.
- First strobe is in the cycle after E0, with the push at E1.
- First out_valid is high after E2.
- out_data and out_ch hold stable while out_valid && !out_ready.
- Full throughput requires D ≥ popcount(mask). Otherwise the FIFO fills and overflow follows.
- Push and pop in the same cycle on a full FIFO is allowed; the push succeeds.
- done is high for exactly one cycle. busy falls in the same cycle that done rises.

## Configuration
- **ADC_CAP_SELF_TEST_EN defined:** the ramp generator and the cfg_self_test mux are built.
- **Undefined:** cfg_self_test is ignored, frames always come from adc_data gated by adc_valid, and no ramp logic is synthesised.

## Structure
- Package adc_cap_pkg holds:
  - The state enum (IDLE/CAPTURE/DRAIN).
  - Default parameter constants.
  - A localparam function for the frame width (CH_NUM*DATA_W).
- Sub-module adc_cap_fifo is a synchronous show-ahead FIFO, DEPTH × (CH_NUM*DATA_W), with full/empty flags.
- The FSM, divider, ramp and serialiser live in the top level.

## Test plan
- **Basic capture:** self-test, mask=2'b11, div=1, len=4, out_ready=1. Expect 8 beats (ch,data): (0,0)(1,1)(0,1)(1,2)(0,2)(1,3)(0,3)(1,4), then done, with frame_cnt=4.
- **Mask and divider:** mask=2'b10, div=3, len=3, adc_data ch1=0x155. Expect 3 beats with ch=1, data=0x155, strobes 3 cycles apart, then done.
- **Overflow:** out_ready=0, DEPTH=64, div=1, continuous mode. After 64 pushes, overflow=1 and frame_cnt stays at 64. Abort and raise out_ready: exactly 64 frames drain, then done.
- **Back-pressure stability:** toggle out_ready randomly. out_data and out_ch must not change while stalled, and no beat is lost or duplicated.
- **Edge cases:** mask=0 start gives done in the cycle after DRAIN with no beats. cfg_start while busy is ignored. rst asserted mid-capture clears all outputs to 0 and out_valid stays low afterward.
